// File: rtl/delay_pkg.sv
// Shared mode encodings and width helpers for the programmable delay line.
package delay_pkg;

  typedef enum logic {
    MODE_TRANSPORT = 1'b0,
    MODE_INERTIAL  = 1'b1
  } dly_mode_e;

  // Bits needed to hold a delay value in 0..max_delay.
  function automatic int delay_width(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/inertial_bit_filter.sv
// One-bit inertial filter: a candidate value plus a stability counter that
// saturates at the programmed delay; stable_o marks a candidate old enough to pass.
module inertial_bit_filter
  import delay_pkg::*;
#(
  parameter int DW = delay_width(16)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_i,
  input  logic          ld_i,
  input  logic          dout_i,
  input  logic [DW-1:0] dly_i,
  output logic          cand_o,
  output logic          stable_o
);

  logic          cand_q, cand_d, base_cand;
  logic [DW-1:0] cnt_q, cnt_d, base_cnt;

  // A load re-seeds the filter from the visible output so nothing toggles spuriously.
  always_comb begin
    base_cand = ld_i ? dout_i : cand_q;
    base_cnt  = ld_i ? dly_i : cnt_q;
    cand_d    = base_cand;
    cnt_d     = base_cnt;
    if (din_i != base_cand) begin
      cand_d = din_i;
      cnt_d  = DW'(1);
    end else if (base_cnt < dly_i) begin
      cnt_d = base_cnt + 1'b1;
    end else begin
      cnt_d = dly_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cand_o   = cand_q;
  assign stable_o = (cnt_q >= dly_i);

endmodule

// File: rtl/prog_delay_line.sv
// Programmable delay line: circular-buffer transport delay or per-bit inertial
// filtering with the same latency; output holds while a new delay is filling.
module prog_delay_line
  import delay_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_DELAY = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WIDTH-1:0]                 din,
  input  logic [$clog2(MAX_DELAY+1)-1:0]   dly_i,
  input  logic                             mode_i,
  input  logic                             ld_i,
  output logic [WIDTH-1:0]                 dout,
  output logic                             valid_o
);

  localparam int DW = delay_width(MAX_DELAY);
  localparam int PW = ptr_width(MAX_DELAY);

  logic [WIDTH-1:0] mem_q [MAX_DELAY];
  logic [WIDTH-1:0] mem_d [MAX_DELAY];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_idx;
  logic [DW-1:0]    dly_q, dly_d, dly_ld, dly_eff;
  logic [DW-1:0]    fill_q, fill_d;
  dly_mode_e        mode_q, mode_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [DW:0]      rd_sum;
  logic [WIDTH-1:0] cand, stable;

  always_comb begin
    dly_ld = dly_i;
    if (dly_i == '0) begin
      dly_ld = DW'(1);
    end else if (dly_i > DW'(MAX_DELAY)) begin
      dly_ld = DW'(MAX_DELAY);
    end
    dly_eff = ld_i ? dly_ld : dly_q;
  end

  // Read index = (wr_ptr - dly) mod MAX_DELAY, biased by MAX_DELAY to stay non-negative.
  always_comb begin
    rd_sum = (DW+1)'(wr_ptr_q) + (DW+1)'(MAX_DELAY) - (DW+1)'(dly_q);
    if (rd_sum >= (DW+1)'(MAX_DELAY)) begin
      rd_sum = rd_sum - (DW+1)'(MAX_DELAY);
    end
    rd_idx = PW'(rd_sum);
  end

  always_comb begin
    mem_d           = mem_q;
    mem_d[wr_ptr_q] = din;
    wr_ptr_d        = (wr_ptr_q == PW'(MAX_DELAY - 1)) ? '0 : wr_ptr_q + 1'b1;
  end

  always_comb begin
    dly_d   = dly_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    valid_d = valid_q;
    if (ld_i) begin
      dly_d   = dly_ld;
      mode_d  = dly_mode_e'(mode_i);
      fill_d  = '0;
      valid_d = 1'b0;
    end else begin
      if (fill_q < dly_q) begin
        fill_d = fill_q + 1'b1;
      end
      valid_d = (fill_d >= dly_q);
    end
  end

  // Output only moves on edges where valid will be high, so reloads hold it steady.
  always_comb begin
    dout_d = dout_q;
    if (valid_d) begin
      if (mode_q == MODE_TRANSPORT) begin
        dout_d = mem_q[rd_idx];
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          dout_d[i] = stable[i] ? cand[i] : dout_q[i];
        end
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_filt
    inertial_bit_filter #(.DW(DW)) u_filt (
      .clk      (clk),
      .rst      (rst),
      .din_i    (din[g]),
      .ld_i     (ld_i),
      .dout_i   (dout_q[g]),
      .dly_i    (dly_eff),
      .cand_o   (cand[g]),
      .stable_o (stable[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_DELAY; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      dly_q    <= DW'(1);
      mode_q   <= MODE_TRANSPORT;
      fill_q   <= '0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      dly_q    <= dly_d;
      mode_q   <= mode_d;
      fill_q   <= fill_d;
      valid_q  <= valid_d;
      dout_q   <= dout_d;
    end
  end

  assign dout    = dout_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// Bench for prog_delay_line: stimulus pushes expected {valid, dout} per edge,
// a negedge monitor pops and compares.
module tb_prog_delay_line;

  localparam int W  = 8;
  localparam int MD = 16;
  localparam int DW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  din;
  logic [DW-1:0] dly_i;
  logic          mode_i;
  logic          ld_i;
  logic [W-1:0]  dout;
  logic          valid_o;

  logic [W:0]    exp_q[$];
  logic [W-1:0]  hist[$];
  logic [W-1:0]  last_dout;
  int            cur_dly;
  int            tests_run = 0;
  int            tests_failed = 0;

  prog_delay_line #(.WIDTH(W), .MAX_DELAY(MD)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .dly_i   (dly_i),
    .mode_i  (mode_i),
    .ld_i    (ld_i),
    .dout    (dout),
    .valid_o (valid_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic reset_model();
    hist.delete();
    for (int i = 0; i < MD; i++) hist.push_back('0);
    last_dout = '0;
    cur_dly   = 1;
  endtask

  // driver: one edge; expected output is either the delayed history entry or a hand value
  task automatic step(input logic [W-1:0] d, input logic ld, input logic [DW-1:0] dl,
                      input logic md, input logic exp_v, input logic use_hist,
                      input logic [W-1:0] exp_hand);
    logic [W-1:0] e;
    din    = d;
    ld_i   = ld;
    dly_i  = dl;
    mode_i = md;
    @(posedge clk);
    #1;
    hist.push_back(d);
    if (exp_v) e = use_hist ? hist[hist.size() - 1 - cur_dly] : exp_hand;
    else       e = last_dout;
    last_dout = e;
    exp_q.push_back({exp_v, e});
    ld_i = 1'b0;
  endtask

  task automatic check_direct(input string name, input logic [W:0] got, input logic [W:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got valid=%0b dout=%02h, expected valid=%0b dout=%02h",
               name, got[W], got[W-1:0], want[W], want[W-1:0]);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [W:0] ent;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        ent = exp_q.pop_front();
        tests_run++;
        if ({valid_o, dout} !== ent) begin
          tests_failed++;
          $display("FAIL out_cmp @%0t: got valid=%0b dout=%02h, expected valid=%0b dout=%02h",
                   $time, valid_o, dout, ent[W], ent[W-1:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; din = '0; dly_i = '0; mode_i = 1'b0; ld_i = 1'b0;
    reset_model();
    #3;
    check_direct("reset_state", {valid_o, dout}, '0);
    #19;
    check_direct("reset_held", {valid_o, dout}, '0);
    rst = 1'b0;

    // default delay 1 right after reset
    step(8'h00, 0, 0, 0, 1, 1, 0);
    step(8'hAA, 0, 0, 0, 1, 1, 0);
    step(8'h55, 0, 0, 0, 1, 1, 0);

    // transport dly=4, ramp
    cur_dly = 4;
    for (int i = 0; i < 12; i++) step(W'(i + 1), i == 0, 5'd4, 0, i >= 4, 1, 0);

    // single-cycle pulse must pass in transport
    for (int i = 0; i < 15; i++) step((i == 6) ? 8'h01 : 8'h00, 0, 0, 0, 1, 1, 0);

    // running stream, then reload to dly=2: output holds until refilled
    for (int i = 0; i < 6; i++) step(W'(8'h20 + i), 0, 0, 0, 1, 1, 0);
    cur_dly = 2;
    for (int i = 0; i < 6; i++) step(W'(8'h10 + i), i == 0, 5'd2, 0, i >= 2, 1, 0);

    // dly=16 across pointer wraps
    cur_dly = 16;
    for (int i = 0; i < 40; i++) step(W'($urandom_range(0, 255)), i == 0, 5'd16, 0, i >= 16, 1, 0);

    // dly=0 behaves as 1
    cur_dly = 1;
    for (int i = 0; i < 6; i++) step(W'(8'h30 + i), i == 0, 5'd0, 0, i >= 1, 1, 0);

    // dly above maximum clamps to 16
    cur_dly = 16;
    for (int i = 0; i < 18; i++) step(W'(8'h40 + i), i == 0, 5'd20, 0, i >= 16, 1, 0);

    // settle output to 0 before inertial tests
    cur_dly = 1;
    for (int i = 0; i < 3; i++) step(8'h00, i == 0, 5'd1, 0, i >= 1, 1, 0);

    // inertial dly=4 hand table
    cur_dly = 4;
    step(8'h00, 1, 5'd4, 1, 0, 0, 8'h00);
    for (int i = 1; i < 4; i++) step(8'h00, 0, 0, 0, 0, 0, 8'h00);
    step(8'h00, 0, 0, 0, 1, 0, 8'h00);
    for (int i = 5; i < 8; i++) step(8'h01, 0, 0, 0, 1, 0, 8'h00);
    for (int i = 8; i < 13; i++) step(8'h00, 0, 0, 0, 1, 0, 8'h00);
    for (int i = 13; i < 17; i++) step(8'h01, 0, 0, 0, 1, 0, 8'h00);
    step(8'h00, 0, 0, 0, 1, 0, 8'h01);
    for (int i = 18; i < 21; i++) step(8'h00, 0, 0, 0, 1, 0, 8'h01);
    step(8'h00, 0, 0, 0, 1, 0, 8'h00);
    for (int i = 22; i < 26; i++) step(8'h81, 0, 0, 0, 1, 0, 8'h00);
    for (int i = 26; i < 30; i++) step(8'h80, 0, 0, 0, 1, 0, 8'h81);
    step(8'h80, 0, 0, 0, 1, 0, 8'h80);

    // transport dly=3, then async reset between edges
    cur_dly = 3;
    step(8'h11, 1, 5'd3, 0, 0, 1, 0);
    step(8'h22, 0, 0, 0, 0, 1, 0);
    step(8'h33, 0, 0, 0, 0, 1, 0);
    step(8'h44, 0, 0, 0, 1, 1, 0);
    step(8'h55, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_direct("async_reset", {valid_o, dout}, '0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    reset_model();
    step(8'h66, 0, 0, 0, 1, 1, 0);
    step(8'h77, 0, 0, 0, 1, 1, 0);
    step(8'h88, 0, 0, 0, 1, 1, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
